btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000: number of consecutive stable synchronized samples that qualify a press or release; legal range >= 2.
REQ-002 SHALL have parameter REPEAT_DELAY, default 50000000: cycles from the initial press pulse to the first auto-repeat pulse; legal range >= 2.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses; legal range >= 2.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port btn_in, input, 1 bit: raw, asynchronous, bouncing push-button level, 1 = pressed.
REQ-007 SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-008 SHALL have port press_pulse, output, 1 bit: registered one-cycle strobe per qualified press or repeat; it drives the display-mode selector trigger.
REQ-009 SHALL have port release_pulse, output, 1 bit: registered one-cycle strobe per qualified release.

Function
REQ-010 SHALL pass btn_in through a 2-flop synchronizer (s1, s2); the FSM uses only s2.
REQ-011 SHALL implement the FSM states IDLE, PRESS_CHK, PRESSED and REL_CHK, with a stability counter cnt sized to ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-012 In IDLE with s2=1, the FSM SHALL go to PRESS_CHK and set cnt=0; with s2=0 it SHALL stay in IDLE.
REQ-013 In PRESS_CHK with s2=0, the FSM SHALL return to IDLE with no pulse (bounce rejected); with s2=1 and cnt<DEBOUNCE_CYCLES-1, it SHALL increment cnt.
REQ-014 In PRESS_CHK with s2=1 and cnt=DEBOUNCE_CYCLES-1, the FSM SHALL go to PRESSED, set btn_level=1, assert press_pulse for one cycle and clear hold_cnt.
REQ-015 Press latency: press_pulse SHALL rise on the (DEBOUNCE_CYCLES+2)th rising edge after the edge at which s1 first samples a stable btn_in=1.
REQ-016 In PRESSED with s2=0, the FSM SHALL go to REL_CHK and set cnt=0.
REQ-017 In REL_CHK with s2=1, the FSM SHALL return to PRESSED with no pulse; with s2=0 it SHALL count, and at cnt=DEBOUNCE_CYCLES-1 it SHALL go to IDLE, set btn_level=0 and assert release_pulse for one cycle.
REQ-018 press_pulse and release_pulse SHALL never be high in the same cycle, and each SHALL never be high for two consecutive cycles.
REQ-019 btn_level SHALL be 1 exactly in PRESSED and REL_CHK.
REQ-020 Counters SHALL saturate and never wrap; a counter reaching its terminal value is consumed by the FSM transition in the same cycle.

Reset
REQ-021 When reset=1 on a rising edge, the block SHALL set s1=0, s2=0, state=IDLE, cnt=0, hold_cnt=0, btn_level=0, press_pulse=0 and release_pulse=0, overriding every other event in that cycle.
REQ-022 Reset asserted mid-debounce or mid-hold SHALL discard progress; if btn_in is still held after reset deasserts, a full new press qualification SHALL occur and produce exactly one press_pulse.

Configuration
REQ-023 With macro BTN_AUTOREPEAT_EN defined, the block SHALL increment hold_cnt each PRESSED cycle and freeze it in REL_CHK.
REQ-024 With BTN_AUTOREPEAT_EN defined, the block SHALL assert press_pulse when hold_cnt reaches REPEAT_DELAY-1 for the first repeat, then every REPEAT_PERIOD cycles, resetting hold_cnt accordingly.
REQ-025 Without BTN_AUTOREPEAT_EN, the block SHALL omit hold_cnt and its logic entirely and produce exactly one press_pulse per qualified press regardless of hold duration.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-026 Clean press: btn_in 0->1 held, sampled at edge 0 -> press_pulse high only after edge 6, btn_level=1 from edge 6.
REQ-027 Bounce: btn_in pattern 1,0,1,1,0 per cycle, then 0 -> no press_pulse, btn_level stays 0, state returns to IDLE.
REQ-028 Release glitch: while pressed, btn_in=0 for 2 cycles then 1 -> no release_pulse, btn_level stays 1; btn_in=0 held -> release_pulse exactly once, 6 edges after first low sample.
REQ-029 Reset mid-press: reset=1 at edge 4 of a qualifying press, then released with btn_in held -> no pulse at edge 6, one press_pulse 6 edges after first post-reset sample, all outputs 0 during reset.
REQ-030 Auto-repeat: hold for 30 cycles after the initial pulse -> with BTN_AUTOREPEAT_EN, pulses at +10, +13, +16, ... +28 (7 repeats); without the macro, only the initial pulse.

Source files
------------

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release strobes.
// Optional auto-repeat of press_pulse while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    REL_CHK
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          s1, s2;
  logic          press_next, release_next;

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(HOLD_MAX);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_cnt, hold_next;
  logic          repeating, repeating_next;
  logic          hold_term;

  // The first repeat waits the long delay; later ones use the shorter period.
  assign hold_term = repeating ? (hold_cnt == PERIOD_LAST) : (hold_cnt == DELAY_LAST);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    hold_next      = hold_cnt;
    repeating_next = repeating;
`endif
    case (state)
      IDLE: begin
        if (s2) begin
          state_next = PRESS_CHK;
          cnt_next   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s2) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          press_next = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          hold_next      = '0;
          repeating_next = 1'b0;
`endif
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_next = REL_CHK;
          cnt_next   = '0;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (hold_term) begin
            press_next     = 1'b1;
            hold_next      = '0;
            repeating_next = 1'b1;
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
`endif
        end
      end
      REL_CHK: begin
        // hold_cnt stays frozen here so a release glitch does not restart the repeat timing.
        if (s2) begin
          state_next = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      hold_cnt      <= '0;
      repeating     <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
`ifdef BTN_AUTOREPEAT_EN
      hold_cnt      <= hold_next;
      repeating     <= repeating_next;
`endif
    end
  end

  assign btn_level = (state == PRESSED) || (state == REL_CHK);

endmodule

// File: tb/tb_btn_debounce.sv
// Randomized and directed bench for btn_debounce, checked every cycle against
// a run-length model of the debounce and hold-time behaviour.
module tb_btn_debounce;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam int EXP_REPEATS = 7;
`else
  localparam int EXP_REPEATS = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level, press_pulse, release_pulse;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Model state: synchronizer copies, debounced level, run of disagreeing samples, held cycles.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0, m_press = 1'b0, m_release = 1'b0;
  int   m_run = 0;
  int   m_held = 0;

  btn_debounce #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // A level flips after D+1 consecutive synchronized samples that disagree with it;
  // repeats fire at RD, RD+RP, RD+2RP ... held-and-stable cycles after the press.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
        m_run = 0; m_held = 0; m_press = 1'b0; m_release = 1'b0;
      end else begin
        m_press = 1'b0;
        m_release = 1'b0;
        if (m_s2 != m_level) begin
          m_run++;
          if (m_run == D + 1) begin
            if (!m_level) begin
              m_press = 1'b1;
              m_held = 0;
            end else begin
              m_release = 1'b1;
            end
            m_level = !m_level;
            m_run = 0;
          end
        end else begin
          if (m_level && m_run == 0) begin
            m_held++;
`ifdef BTN_AUTOREPEAT_EN
            if (m_held >= RD && (m_held - RD) % RP == 0) m_press = 1'b1;
`endif
          end
          m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = btn_in;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if (btn_level !== m_level) begin
        miscompares++;
        $display("[TB] FAIL level at %0t: got %b, want %b", $time, btn_level, m_level);
      end
      vectors++;
      if (press_pulse !== m_press) begin
        miscompares++;
        $display("[TB] FAIL press at %0t: got %b, want %b", $time, press_pulse, m_press);
      end
      vectors++;
      if (release_pulse !== m_release) begin
        miscompares++;
        $display("[TB] FAIL release at %0t: got %b, want %b", $time, release_pulse, m_release);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Drives btn_in/reset for n edges; edge index 0 is the first edge that samples them.
  task automatic applyStimulus(input logic b, input logic r, input int n,
                               output int presses, output int releases,
                               output int firstPress, output int firstRelease,
                               output int modelPresses);
    presses = 0; releases = 0; firstPress = -1; firstRelease = -1; modelPresses = 0;
    btn_in = b;
    reset  = r;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (press_pulse === 1'b1) begin
        presses++;
        if (firstPress < 0) firstPress = i;
      end
      if (release_pulse === 1'b1) begin
        releases++;
        if (firstRelease < 0) firstRelease = i;
      end
      if (m_press) modelPresses++;
    end
  endtask

  initial begin
    int np, nr, fp, fr, mp;
    int totP, totR;
    logic pat [5];
    logic b, r;
    int len;

    reset = 1'b1;
    btn_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    checkOutput("reset level", int'(btn_level), 0);
    checkOutput("reset press", int'(press_pulse), 0);
    checkOutput("reset release", int'(release_pulse), 0);

    // Clean press, then a long hold for auto-repeat.
    applyStimulus(1'b1, 1'b0, 7, np, nr, fp, fr, mp);
    checkOutput("clean press edge", fp, 6);
    checkOutput("clean press count", np, 1);
    checkOutput("model press count", mp, 1);
    checkOutput("clean level", int'(btn_level), 1);
    applyStimulus(1'b1, 1'b0, 30, np, nr, fp, fr, mp);
    checkOutput("repeat count", np, EXP_REPEATS);
    checkOutput("model repeat count", mp, EXP_REPEATS);
`ifdef BTN_AUTOREPEAT_EN
    checkOutput("first repeat offset", fp + 1, 10);
`endif

    // Short release glitch is rejected, then a real release.
    applyStimulus(1'b0, 1'b0, 2, np, nr, fp, fr, mp);
    totR = nr;
    applyStimulus(1'b1, 1'b0, 10, np, nr, fp, fr, mp);
    totR += nr;
    checkOutput("glitch release count", totR, 0);
    checkOutput("glitch level", int'(btn_level), 1);
    applyStimulus(1'b0, 1'b0, 12, np, nr, fp, fr, mp);
    checkOutput("release edge", fr, 6);
    checkOutput("release count", nr, 1);
    checkOutput("released level", int'(btn_level), 0);

    // Bounce pattern never qualifies.
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;
    totP = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(pat[i], 1'b0, 1, np, nr, fp, fr, mp);
      totP += np;
    end
    applyStimulus(1'b0, 1'b0, 10, np, nr, fp, fr, mp);
    totP += np;
    checkOutput("bounce press count", totP, 0);
    checkOutput("bounce level", int'(btn_level), 0);

    // Reset at edge 4 of a qualifying press discards progress.
    applyStimulus(1'b1, 1'b0, 4, np, nr, fp, fr, mp);
    totP = np;
    applyStimulus(1'b1, 1'b1, 2, np, nr, fp, fr, mp);
    totP += np;
    checkOutput("in-reset level", int'(btn_level), 0);
    checkOutput("in-reset press", int'(press_pulse), 0);
    checkOutput("pre-reset press count", totP, 0);
    applyStimulus(1'b1, 1'b0, 10, np, nr, fp, fr, mp);
    checkOutput("post-reset press edge", fp, 6);
    checkOutput("post-reset press count", np, 1);
    applyStimulus(1'b0, 1'b0, 10, np, nr, fp, fr, mp);

    // Random segments of held levels with occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 39) == 0);
      if (r) len = $urandom_range(1, 3);
      else if ($urandom_range(0, 9) == 0) len = $urandom_range(10, 40);
      else len = $urandom_range(1, 7);
      applyStimulus(b, r, len, np, nr, fp, fr, mp);
    end
    applyStimulus(1'b0, 1'b0, 12, np, nr, fp, fr, mp);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
